scan_click_driver: RTL and testbench

- Initiator side of the 4-digit 7-segment display interface.
- Generates the active-low anode strobes (an3..an0) and the 4-bit click counter (0..14 wrap) consumed by the message source.
- Samples the 6-bit character code the source returns and decodes it to active-low segments for the board display.
- Also debounces the raw push-button that advances the message.

---
 rtl/scan_click_driver.sv | 180 ++++++++++++++++++
 tb/tb_scan_click_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/scan_click_driver.sv
// ----------------------------------------------------------------------------
// scan_click_driver
//   Initiator side of a 4-digit multiplexed 7-segment display. It scans the
//   four active-low anodes in the order an3, an2, an1, an0. Before each slot
//   it inserts a blank window. The source uses that window to present the
//   character for next_digit, and the code is decoded into seg. The block
//   also debounces a push-button into click_pulse and click_counter.
//
//   Optional build macro: SCAN_DIM_EN. It adds a 'dim' input. While dim is
//   high, the anode is lit only for the first half of each slot.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   click_raw         : asynchronous button level, active-high
//   char_in[5:0]      : character code for the digit about to be lit
//   dim               : (SCAN_DIM_EN only) half-duty anode drive
//   an3..an0          : anode strobes, active-low (an3 = leftmost)
//   next_digit[1:0]   : digit lit by the upcoming/current slot
//   click_counter[3:0]: message rotation position, 0..MSG_LAST
//   click_pulse       : one-cycle strobe per accepted press
//   seg[6:0]          : {a,b,c,d,e,f,g}, active-low
// ----------------------------------------------------------------------------
module scan_click_driver #(
   parameter int DIGIT_PERIOD    = 16,
   parameter int BLANK_CYCLES    = 4,
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int MSG_LAST        = 14
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       click_raw,
   input  logic [5:0] char_in,
`ifdef SCAN_DIM_EN
   input  logic       dim,
`endif
   output logic       an3,
   output logic       an2,
   output logic       an1,
   output logic       an0,
   output logic [1:0] next_digit,
   output logic [3:0] click_counter,
   output logic       click_pulse,
   output logic [6:0] seg
);

   localparam int CNT_MAX = (DIGIT_PERIOD > BLANK_CYCLES) ? DIGIT_PERIOD : BLANK_CYCLES;
   localparam int CW      = $clog2(CNT_MAX);
   localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] ACT_LAST   = CW'(DIGIT_PERIOD - 1);
   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]    MSG_TOP    = 4'(MSG_LAST);

   typedef enum logic {BLANK, ACTIVE} state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [1:0]      nd_q;
   logic [6:0]      seg_q, seg_d;
   logic [3:0]      an_q, an_d;
   logic            lit;

   logic [1:0]      sync_q;
   logic            deb_q;
   logic [DW-1:0]   dcnt_q;
   logic [3:0]      cc_q;
   logic            pulse_q;

   // ---------------------------------------------------------------- decoder
   function automatic logic [6:0] decode(input logic [5:0] c);
      logic [6:0] s;
      case (c)
         6'd0:  s = 7'b0000001;
         6'd1:  s = 7'b1001111;
         6'd2:  s = 7'b0010010;
         6'd3:  s = 7'b0000110;
         6'd4:  s = 7'b1001100;
         6'd5:  s = 7'b0100100;
         6'd6:  s = 7'b0100000;
         6'd7:  s = 7'b0001111;
         6'd8:  s = 7'b0000000;
         6'd9:  s = 7'b0000100;
         6'd10: s = 7'b0001000; // A
         6'd15: s = 7'b0111000; // F
         6'd16: s = 7'b0100000; // G
         6'd23: s = 7'b1101010; // N
         6'd25: s = 7'b0011000; // P
         6'd27: s = 7'b1111010; // R
         6'd28: s = 7'b0100100; // S
         6'd29: s = 7'b1110000; // T
         default: s = 7'h7F;    // space and undefined codes
      endcase
      return s;
   endfunction

   assign seg_d = decode(char_in);

`ifdef SCAN_DIM_EN
   assign lit = !dim || (cnt_q < CW'(DIGIT_PERIOD / 2));
`else
   assign lit = 1'b1;
`endif

   // The anodes are registered from the current state. They therefore lag
   // the state by one cycle. As a result, an anode falls one cycle after seg
   // is loaded, and it stays low for exactly DIGIT_PERIOD cycles.
   always_comb begin
      an_d = 4'hF;
      if (state_q == ACTIVE && lit) an_d[nd_q] = 1'b0;
   end

   // ------------------------------------------------------------- scan FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= BLANK;
         cnt_q   <= '0;
         nd_q    <= 2'd3;
         seg_q   <= 7'h7F;
         an_q    <= 4'hF;
      end else begin
         an_q <= an_d;
         case (state_q)
            BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  seg_q   <= seg_d;
                  cnt_q   <= '0;
                  state_q <= ACTIVE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ACTIVE: begin
               if (cnt_q == ACT_LAST) begin
                  nd_q    <= nd_q - 2'd1; // 3->2->1->0->3
                  cnt_q   <= '0;
                  state_q <= BLANK;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= BLANK;
         endcase
      end
   end

   // ----------------------------------------------------------- button path
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= 2'b00;
         deb_q   <= 1'b0;
         dcnt_q  <= '0;
         cc_q    <= 4'd0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], click_raw};
         pulse_q <= 1'b0;
         if (sync_q[1] == deb_q) begin
            dcnt_q <= '0;
         end else if (dcnt_q == DEB_LAST) begin
            // The level has differed for DEBOUNCE_CYCLES cycles, so accept it.
            dcnt_q <= '0;
            deb_q  <= sync_q[1];
            if (sync_q[1]) begin
               pulse_q <= 1'b1;
               cc_q    <= (cc_q == MSG_TOP) ? 4'd0 : cc_q + 4'd1;
            end
         end else begin
            dcnt_q <= dcnt_q + 1'b1;
         end
      end
   end

   assign {an3, an2, an1, an0} = an_q;
   assign next_digit    = nd_q;
   assign seg           = seg_q;
   assign click_counter = cc_q;
   assign click_pulse   = pulse_q;

endmodule

// File: tb/tb_scan_click_driver.sv
// ----------------------------------------------------------------------------
// tb_scan_click_driver
//   Directed bench for scan_click_driver with default parameters. A small
//   source model drives char_in from next_digit.
// ----------------------------------------------------------------------------
module tb_scan_click_driver;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       click_raw = 1'b0;
   logic [5:0] char_in;
   logic       an3, an2, an1, an0;
   logic [1:0] next_digit;
   logic [3:0] click_counter;
   logic       click_pulse;
   logic [6:0] seg;

   int checks = 0;
   int fails  = 0;
   bit src_mode = 1'b0;

   scan_click_driver dut (
      .clk(clk), .reset(reset), .click_raw(click_raw), .char_in(char_in),
      .an3(an3), .an2(an2), .an1(an1), .an0(an0), .next_digit(next_digit),
      .click_counter(click_counter), .click_pulse(click_pulse), .seg(seg)
   );

   always #5 clk = ~clk;

   // Message source: mode 0 returns '3' everywhere. Mode 1 returns F,P,G,A
   // for digits 3,2,1,0.
   always_comb begin
      char_in = 6'd3;
      if (src_mode) begin
         case (next_digit)
            2'd3: char_in = 6'd15;
            2'd2: char_in = 6'd25;
            2'd1: char_in = 6'd16;
            default: char_in = 6'd10;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
   endtask

   // Check one full frame. The call starts at the first cycle of an3 low, and
   // the task leaves at the same point of the next frame.
   task automatic check_frame(input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0,
                              input bit chk_seg);
      logic [6:0] exp_seg [4];
      exp_seg[0] = s3; exp_seg[1] = s2; exp_seg[2] = s1; exp_seg[3] = s0;
      for (int t = 0; t < 80; t++) begin
         int slot, pos;
         logic [3:0] exp_an;
         slot = t / 20;
         pos  = t % 20;
         exp_an = 4'hF;
         if (pos < 16) exp_an[3 - slot] = 1'b0;
         chk("frame_an", {an3, an2, an1, an0}, exp_an);
         if (chk_seg && pos < 16) chk("frame_seg", seg, exp_seg[slot]);
         step();
      end
   endtask

   task automatic press(input logic [3:0] exp_cc);
      bit seen;
      seen = 1'b0;
      click_raw = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (click_pulse) begin seen = 1'b1; break; end
      end
      chk("press_pulse", seen, 1);
      chk("press_cc", click_counter, exp_cc);
      repeat (12) step();
      click_raw = 1'b0;
      repeat (14) step();
   endtask

   initial begin
      int k;
      int npulse;

      // Reset values.
      reset = 1'b1;
      step(); step();
      chk("rst_an", {an3, an2, an1, an0}, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_nd", next_digit, 2'd3);
      chk("rst_cc", click_counter, 4'd0);
      chk("rst_pulse", click_pulse, 1'b0);

      // First anode: an3 falls after the fifth edge that follows release.
      reset = 1'b0;
      k = 0;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (an3 == 1'b0) begin k = i; break; end
      end
      chk("first_an3_cycle", k, 5);
      chk("first_seg", seg, 7'b0000110);

      // Frame with char 3 everywhere, then switch to the F,P,G,A source.
      check_frame(7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110, 1'b1);
      src_mode = 1'b1;
      check_frame(7'h00, 7'h00, 7'h00, 7'h00, 1'b0);
      check_frame(7'b0111000, 7'b0011000, 7'b0100000, 7'b0001000, 1'b1);

      // Single clean press. The pulse comes 10 cycles after the edge, and
      // the release produces no pulse.
      click_raw = 1'b1;
      k = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (click_pulse) begin k = i; break; end
      end
      chk("press_latency", k, 10);
      chk("press_cc1", click_counter, 4'd1);
      step();
      chk("pulse_one_cycle", click_pulse, 1'b0);
      npulse = 0;
      for (int i = 0; i < 9; i++) begin step(); npulse += int'(click_pulse); end
      click_raw = 1'b0;
      for (int i = 0; i < 20; i++) begin step(); npulse += int'(click_pulse); end
      chk("no_release_pulse", npulse, 0);
      chk("release_cc", click_counter, 4'd1);

      // A 3-cycle glitch is ignored.
      click_raw = 1'b1;
      step(); step(); step();
      click_raw = 1'b0;
      npulse = 0;
      for (int i = 0; i < 20; i++) begin step(); npulse += int'(click_pulse); end
      chk("glitch_pulse", npulse, 0);
      chk("glitch_cc", click_counter, 4'd1);

      // 15 presses from reset: the counter goes 1..14 and then wraps to 0.
      do_reset();
      for (int i = 1; i <= 15; i++) press(4'((i) % 15));

      // Take the counter to 7, then reset in the middle of an ACTIVE slot.
      for (int i = 1; i <= 7; i++) press(4'(i));
      chk("pre_rst_cc", click_counter, 4'd7);
      k = 0;
      for (int i = 1; i <= 30; i++) begin
         if ({an3, an2, an1, an0} != 4'hF) begin k = i; break; end
         step();
      end
      chk("found_active", (k != 0), 1);
      repeat (5) step();
      reset = 1'b1;
      step();
      chk("mid_rst_an", {an3, an2, an1, an0}, 4'hF);
      chk("mid_rst_cc", click_counter, 4'd0);
      chk("mid_rst_seg", seg, 7'h7F);
      chk("mid_rst_nd", next_digit, 2'd3);
      reset = 1'b0;

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
